// File: rtl/rinv_collect_pkg.sv
// Shared defaults and state encoding for the R-inverse result collector.
// Imported by the channel capture sub-module and the top.
package rinv_collect_pkg;

   localparam int unsigned DW_DEFAULT      = 32;
   localparam int unsigned TIMEOUT_DEFAULT = 64;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_OUTPUT  = 1'b1
   } rinvState_e;

   // Counter width able to hold every value up to TIMEOUT-1.
   function automatic int unsigned cntWidth(input int unsigned timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/rinv_collect_chan_capture.sv
// One divider result channel: a captured flag, a data register and the
// tready it implies. The top decides when capture is allowed and when to clear.
module rinv_chan_capture
   import rinv_collect_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          enable_i,
   input  logic          clear_i,
   input  logic          tvalid_i,
   input  logic [DW-1:0] tdata_i,
   output logic          tready_o,
   output logic          fire_o,
   output logic          captured_o,
   output logic [DW-1:0] data_o
);

   logic          flag_q, flag_d;
   logic [DW-1:0] data_q, data_d;

   assign tready_o   = enable_i && !flag_q;
   assign fire_o     = tvalid_i && tready_o;
   assign captured_o = flag_q;
   assign data_o     = data_q;

   // Clearing wins over a same-edge capture; the data word is kept regardless.
   always_comb begin
      flag_d = flag_q;
      data_d = data_q;
      if (fire_o) begin
         flag_d = 1'b1;
         data_d = tdata_i;
      end
      if (clear_i) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flag_q <= 1'b0;
         data_q <= '0;
      end else begin
         flag_q <= flag_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/rinv_collect.sv
// Gathers the three divider results of one R-inverse set, presents the
// assembled 2x2 matrix, and discards sets that do not complete in time.
module rinv_collect
   import rinv_collect_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned DW      = DW_DEFAULT
) (
   input  logic          I_sys_clk,
   input  logic          I_sys_rst,
   input  logic          I_r11_tvalid,
   input  logic [DW-1:0] I_r11_tdata,
   input  logic          I_r12_tvalid,
   input  logic [DW-1:0] I_r12_tdata,
   input  logic          I_r22_tvalid,
   input  logic [DW-1:0] I_r22_tdata,
   output logic          O_r11_tready,
   output logic          O_r12_tready,
   output logic          O_r22_tready,
   output logic [DW-1:0] O_R11_inv,
   output logic [DW-1:0] O_R12_inv,
   output logic [DW-1:0] O_R21_inv,
   output logic [DW-1:0] O_R22_inv,
   output logic          O_valid,
   input  logic          I_ready,
   output logic          O_timeout
);

   localparam int unsigned   CW       = cntWidth(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   rinvState_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cntNext;
   logic          timeout_q, timeout_d;
   logic          live_q;

   logic          collectEn, clearFlags, setDone, expire, consume, anyAfter;
   logic [2:0]    fire, captured, flagsAfter;

   rinv_chan_capture #(.DW(DW)) u_r11 (
      .clk_i      (I_sys_clk),
      .rst_i      (I_sys_rst),
      .enable_i   (collectEn),
      .clear_i    (clearFlags),
      .tvalid_i   (I_r11_tvalid),
      .tdata_i    (I_r11_tdata),
      .tready_o   (O_r11_tready),
      .fire_o     (fire[0]),
      .captured_o (captured[0]),
      .data_o     (O_R11_inv)
   );

   rinv_chan_capture #(.DW(DW)) u_r12 (
      .clk_i      (I_sys_clk),
      .rst_i      (I_sys_rst),
      .enable_i   (collectEn),
      .clear_i    (clearFlags),
      .tvalid_i   (I_r12_tvalid),
      .tdata_i    (I_r12_tdata),
      .tready_o   (O_r12_tready),
      .fire_o     (fire[1]),
      .captured_o (captured[1]),
      .data_o     (O_R12_inv)
   );

   rinv_chan_capture #(.DW(DW)) u_r22 (
      .clk_i      (I_sys_clk),
      .rst_i      (I_sys_rst),
      .enable_i   (collectEn),
      .clear_i    (clearFlags),
      .tvalid_i   (I_r22_tvalid),
      .tdata_i    (I_r22_tdata),
      .tready_o   (O_r22_tready),
      .fire_o     (fire[2]),
      .captured_o (captured[2]),
      .data_o     (O_R22_inv)
   );

   // live_q holds tready low until the first edge after reset is released.
   assign collectEn  = live_q && (state_q == ST_COLLECT);
   assign flagsAfter = captured | fire;
   assign anyAfter   = |flagsAfter;
   assign setDone    = collectEn && (&flagsAfter);
   assign cntNext    = (|captured) ? (cnt_q + CW'(1)) : '0;
   assign expire     = collectEn && !setDone && anyAfter && (cntNext == CNT_LAST);
   assign consume    = (state_q == ST_OUTPUT) && I_ready;
   assign clearFlags = expire || consume;

   // A completing handshake on the expiry edge counts as completion.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (setDone) begin
               state_d = ST_OUTPUT;
               cnt_d   = '0;
            end else if (expire) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else if (anyAfter) begin
               cnt_d = cntNext;
            end else begin
               cnt_d = '0;
            end
         end
         ST_OUTPUT: begin
            if (I_ready) begin
               state_d = ST_COLLECT;
            end
         end
         default: begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_sys_rst) begin
         state_q   <= ST_COLLECT;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         live_q    <= 1'b1;
      end
   end

   assign O_valid   = (state_q == ST_OUTPUT);
   assign O_timeout = timeout_q;
   assign O_R21_inv = '0;

endmodule

// File: tb/tb_rinv_collect.sv
// Randomised scoreboard bench for rinv_collect: a set-level reference model
// predicts matrices and timeouts, a separate monitor checks the DUT outputs.
module tb_rinv_collect;
   import rinv_collect_pkg::*;

   localparam int DW      = 32;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic [DW-1:0] r11;
      logic [DW-1:0] r12;
      logic [DW-1:0] r22;
   } mat_t;

   logic          clock = 1'b0;
   logic          rst;
   logic [2:0]    tvalid;
   logic [DW-1:0] tdata [3];
   logic [2:0]    tready;
   logic [DW-1:0] r11Inv, r12Inv, r21Inv, r22Inv;
   logic          oValid, iReady, oTimeout;

   always #5 clock = ~clock;

   rinv_collect #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
      .I_sys_clk    (clock),
      .I_sys_rst    (rst),
      .I_r11_tvalid (tvalid[0]),
      .I_r11_tdata  (tdata[0]),
      .I_r12_tvalid (tvalid[1]),
      .I_r12_tdata  (tdata[1]),
      .I_r22_tvalid (tvalid[2]),
      .I_r22_tdata  (tdata[2]),
      .O_r11_tready (tready[0]),
      .O_r12_tready (tready[1]),
      .O_r22_tready (tready[2]),
      .O_R11_inv    (r11Inv),
      .O_R12_inv    (r12Inv),
      .O_R21_inv    (r21Inv),
      .O_R22_inv    (r22Inv),
      .O_valid      (oValid),
      .I_ready      (iReady),
      .O_timeout    (oTimeout)
   );

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;
   bit started     = 1'b0;

   // Set-level reference model state
   bit [2:0]      held        = '0;
   logic [DW-1:0] word [3];
   bit            inOut       = 1'b0;
   bit            live        = 1'b0;
   bit            timeoutPend = 1'b0;
   int            firstCap    = 0;
   bit [2:0]      lastFire    = '0;
   mat_t          matQ [$];

   // Expectations for the current cycle, published before the model advances
   bit [2:0]      expReady    = '0;
   bit            expValid    = 1'b0;
   bit            expTimeout  = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // Reference model: decides at mid-cycle what the coming edge does.
   initial begin
      bit [2:0] fires;
      int       edgeNo;
      mat_t     m;
      forever begin
         @(negedge clock);
         for (int c = 0; c < 3; c++) expReady[c] = live && !inOut && !held[c];
         expValid   = inOut;
         expTimeout = timeoutPend;
         fires      = tvalid & expReady;
         if (rst) begin
            held        = '0;
            inOut       = 1'b0;
            live        = 1'b0;
            timeoutPend = 1'b0;
            fires       = '0;
            matQ.delete();
         end else begin
            edgeNo      = cyc + 1;
            timeoutPend = 1'b0;
            if (inOut) begin
               if (iReady) begin
                  inOut = 1'b0;
                  held  = '0;
               end
            end else begin
               if (held == 3'b000 && fires != 3'b000) firstCap = edgeNo;
               for (int c = 0; c < 3; c++) begin
                  if (fires[c]) begin
                     held[c] = 1'b1;
                     word[c] = tdata[c];
                  end
               end
               if (held == 3'b111) begin
                  inOut = 1'b1;
                  m.r11 = word[0];
                  m.r12 = word[1];
                  m.r22 = word[2];
                  matQ.push_back(m);
               end else if (held != 3'b000 && (edgeNo - firstCap) == TIMEOUT - 1) begin
                  held        = '0;
                  timeoutPend = 1'b1;
               end
            end
            live = 1'b1;
         end
         lastFire = fires;
      end
   end

   task automatic checkOutput();
      mat_t m;
      testsRun++;
      if (tready !== expReady) begin
         testsFailed++;
         $display("[TB] FAIL tready cyc=%0d: got %b, expected %b", cyc, tready, expReady);
      end
      testsRun++;
      if (oValid !== expValid) begin
         testsFailed++;
         $display("[TB] FAIL O_valid cyc=%0d: got %b, expected %b", cyc, oValid, expValid);
      end
      testsRun++;
      if (oTimeout !== expTimeout) begin
         testsFailed++;
         $display("[TB] FAIL O_timeout cyc=%0d: got %b, expected %b", cyc, oTimeout, expTimeout);
      end
      if (oValid === 1'b1 && !rst) begin
         testsRun++;
         if (matQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL matrix cyc=%0d: got valid output, expected no pending set", cyc);
         end else begin
            m = matQ[0];
            if (r11Inv !== m.r11 || r12Inv !== m.r12 || r22Inv !== m.r22 || r21Inv !== '0) begin
               testsFailed++;
               $display("[TB] FAIL matrix cyc=%0d: got %h %h %h %h, expected %h %h 00000000 %h",
                        cyc, r11Inv, r12Inv, r21Inv, r22Inv, m.r11, m.r12, m.r22);
            end
            if (iReady) void'(matQ.pop_front());
         end
      end
   endtask

   // Monitor: runs after the model has published this cycle's expectations.
   initial begin
      wait (started == 1'b1);
      forever begin
         @(negedge clock);
         #2;
         checkOutput();
      end
   end

   int pv [3];
   int pr;
   int mode;
   int off;
   int rstLeft;

   task automatic applyStimulus();
      @(posedge clock);
      #1;
      for (int c = 0; c < 3; c++) begin
         if (lastFire[c] || !tvalid[c]) tdata[c] = $urandom;
      end
      if (mode == 0) begin
         for (int c = 0; c < 3; c++) tvalid[c] = ($urandom_range(99) < pv[c]);
      end else begin
         if (held == 3'b000) off = int'($urandom_range(2)) - 1;
         tvalid[0] = 1'b1;
         tvalid[2] = 1'b1;
         tvalid[1] = held[0] && held[2] && !inOut &&
                     ((cyc + 1 - firstCap) == TIMEOUT - 1 + off);
      end
      iReady = ($urandom_range(99) < pr);
      if (rstLeft == 0 && $urandom_range(299) == 0) rstLeft = $urandom_range(3, 1);
      rst = (rstLeft > 0);
      if (rstLeft > 0) rstLeft--;
   endtask

   initial begin
      int probTable [5];
      int readyTable [3];
      probTable  = '{0, 15, 50, 90, 100};
      readyTable = '{20, 60, 100};
      rst     = 1'b1;
      tvalid  = '0;
      iReady  = 1'b0;
      mode    = 0;
      off     = 0;
      rstLeft = 0;
      for (int c = 0; c < 3; c++) tdata[c] = $urandom;

      repeat (3) @(posedge clock);
      @(negedge clock);
      #4;
      testsRun++;
      if (oValid !== 1'b0 || oTimeout !== 1'b0 || tready !== 3'b000 ||
          r11Inv !== '0 || r12Inv !== '0 || r21Inv !== '0 || r22Inv !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset: got v=%b t=%b rdy=%b %h %h %h %h, expected all zero",
                  oValid, oTimeout, tready, r11Inv, r12Inv, r21Inv, r22Inv);
      end
      started = 1'b1;
      @(posedge clock);
      #1;
      rst = 1'b0;

      for (int p = 0; p < 14; p++) begin
         mode = (p % 3 == 2) ? 1 : 0;
         for (int c = 0; c < 3; c++) pv[c] = probTable[$urandom_range(4)];
         pr = readyTable[$urandom_range(2)];
         repeat (500) applyStimulus();
      end

      @(posedge clock);
      #1;
      rst     = 1'b0;
      rstLeft = 0;
      tvalid  = '0;
      iReady  = 1'b1;
      repeat (150) @(posedge clock);
      @(negedge clock);
      #4;
      testsRun++;
      if (matQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d undelivered sets, expected 0", matQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/rinv_collect.md
RINV_COLLECT -- requirements
Module: rinv_collect

Interface
REQ-001 Parameter: TIMEOUT, default 64, cycles allowed from first channel capture to completion of the set.
REQ-002 Parameter: DW, default 32, width of each divider result word.
REQ-003 I_sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 I_sys_rst  input  1  reset, synchronous, active-high.
REQ-005 I_r11_tvalid / I_r11_tdata  input  1 / DW  divider result stream for 1/R11.
REQ-006 I_r12_tvalid / I_r12_tdata  input  1 / DW  divider result stream for -R12/(R11*R22).
REQ-007 I_r22_tvalid / I_r22_tdata  input  1 / DW  divider result stream for 1/R22.
REQ-008 O_r11_tready, O_r12_tready, O_r22_tready  output  1 each  per-channel ready.
REQ-009 O_R11_inv, O_R12_inv, O_R21_inv, O_R22_inv  output  DW each  assembled R-inverse matrix.
REQ-010 O_valid  output  1  matrix valid; I_ready  input  1  downstream accept.
REQ-011 O_timeout  output  1  one-cycle pulse: incomplete set discarded.

Function
REQ-012 Channel handshake occurs when tvalid and tready are both high on a rising edge; tdata is captured into that channel's register on that edge.
REQ-013 FSM states: COLLECT, OUTPUT; reset state COLLECT.
REQ-014 In COLLECT, each O_rXX_tready is high iff that channel is not yet captured; in OUTPUT all tready are low.
REQ-015 Each channel captures at most one word per set; further tvalid on a captured channel is back-pressured.
REQ-016 Channels may complete in any order and in the same cycle; COLLECT -> OUTPUT on the edge where the last uncaptured channel handshakes.
REQ-017 O_valid is high in OUTPUT only, first asserted one cycle after the final capture edge.
REQ-018 O_R11_inv, O_R12_inv, O_R22_inv hold captured words unchanged while O_valid is high; O_R21_inv is constant zero.
REQ-019 OUTPUT -> COLLECT on the edge where O_valid and I_ready are both high; all capture flags clear on that edge; tready rises the following cycle.
REQ-020 Timeout counter starts at 0 on the first capture of a set, increments each COLLECT cycle while the set is incomplete, is idle when no channel captured.
REQ-021 If the counter reaches TIMEOUT-1 while still incomplete and no completing handshake occurs that edge, O_timeout pulses one cycle, all capture flags and the counter clear, FSM stays COLLECT.
REQ-022 A completing handshake on the same edge as timeout expiry takes precedence: set completes, no timeout pulse.
REQ-023 Data registers are not cleared on timeout or consumption; only flags clear.

Reset
REQ-024 On I_sys_rst high at a clock edge: FSM=COLLECT, capture flags=0, counter=0, O_valid=0, O_timeout=0, all tready=0, data outputs=0.
REQ-025 tready rises the first cycle after I_sys_rst deasserts; reset mid-set or mid-OUTPUT discards the set with no O_timeout pulse.

Structure
REQ-026 Shared package holds DW default, TIMEOUT default, and FSM state encoding.
REQ-027 One sub-module, rinv_chan_capture (flag, register, tready per channel), instantiated three times.

Verification
REQ-028 Reset, then r11=0x0000_0100, r12=0xFFFF_FF00, r22=0x0000_0080 valid same cycle, I_ready=1 -> O_valid one cycle later, outputs match, O_R21_inv=0, tready high next cycle.
REQ-029 Staggered order r22@t, r11@t+5, r12@t+9, I_ready=0 for 4 cycles -> O_valid from t+10, held stable until I_ready, all tready low throughout OUTPUT.
REQ-030 r11 sent twice before r12/r22 -> second r11 stalls (tready low) and is captured into the next set.
REQ-031 r11 only, TIMEOUT=64 -> O_timeout single pulse 63 cycles after capture, flags clear, next full set outputs correctly.
REQ-032 Last channel handshakes exactly on expiry cycle -> O_valid, no O_timeout.
REQ-033 I_sys_rst asserted while O_valid high -> O_valid 0 next edge, no timeout pulse, fresh set collects normally.
